// File: rtl/vreg_pkg.sv
// vreg_pkg: shared state encoding and output-buffer sizing for the vector register read sequencer
package vreg_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/vreg_skid_fifo.sv
// vreg_skid_fifo: 2-entry output buffer; output forced to zero while empty so a flushed buffer shows no stale data
module vreg_skid_fifo
  import vreg_pkg::*;
#(
  parameter int W = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  // pointers and occupancy; flush empties the buffer like reset does
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PTR_W'(push);
      rd_q  <= rd_q + PTR_W'(pop);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // storage needs no reset: contents are only visible through valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign valid = cnt_q != '0;
  assign count = cnt_q;
  assign dout  = valid ? mem_q[rd_q] : '0;
endmodule

// File: rtl/vreg_read_sequencer.sv
// vreg_read_sequencer: streams vl RAM elements from base; define VREG_SEQ_STRIDE_EN to add a captured stride input
module vreg_read_sequencer
  import vreg_pkg::*;
#(
  parameter int DATA = 64,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR-1:0] base,
  input  logic [ADDR:0]   vl,
`ifdef VREG_SEQ_STRIDE_EN
  input  logic [ADDR-1:0] stride,
`endif
  input  logic            abort,
  output logic            ram_rd,
  output logic [ADDR-1:0] ram_addr,
  input  logic [DATA-1:0] ram_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
);
  localparam logic [ADDR:0]  cnt_one = {{ADDR{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] depth_c = (CNT_W + 1)'(FIFO_DEPTH);
  state_t           state_q;
  logic [ADDR-1:0]  addr_q, inc;
  logic [ADDR:0]    cnt_q;
  logic             inflight_q, inflight_last_q, done_q;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   occ;
  logic [DATA:0]    fifo_dout;
  logic             fifo_valid, pop, push, flush, last_issue, drained;
`ifdef VREG_SEQ_STRIDE_EN
  logic [ADDR-1:0]  stride_q;
  assign inc = stride_q;
`else
  assign inc = ADDR'(1);
`endif
  assign pop        = fifo_valid && out_ready;
  assign flush      = abort && state_q != IDLE;
  assign push       = inflight_q && !flush;
  assign occ        = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
  assign ram_rd     = state_q == RUN && !abort && (occ < depth_c || pop);
  assign last_issue = ram_rd && cnt_q == cnt_one;
  assign drained    = !inflight_q && fifo_cnt == {{(CNT_W-1){1'b0}}, pop};
  assign ram_addr   = addr_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign out_valid  = fifo_valid;
  assign out_data   = fifo_dout[DATA-1:0];
  assign out_last   = fifo_dout[DATA];
`ifdef VREG_SEQ_STRIDE_EN
  // stride is latched with the command so it cannot change mid-vector
  always_ff @(posedge clk) begin
    if (rst) stride_q <= '0;
    else if (state_q == IDLE && start) stride_q <= stride;
  end
`endif
  // command FSM: issue counter, address walk, in-flight tracking and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= ram_rd;
      inflight_last_q <= last_issue;
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= base;
          cnt_q   <= vl;
          done_q  <= vl == '0;
          state_q <= vl == '0 ? IDLE : RUN;
        end
        RUN: if (abort) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end else if (ram_rd) begin
          addr_q  <= addr_q + inc;
          cnt_q   <= cnt_q - cnt_one;
          state_q <= last_issue ? DRAIN : RUN;
        end
        DRAIN: if (abort || drained) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  vreg_skid_fifo #(.W(DATA + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   ({inflight_last_q, ram_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_vreg_read_sequencer.sv
// tb_vreg_read_sequencer: table-driven commands plus abort, reset and stride sequences against a registered RAM model
module tb_vreg_read_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  base = '0;
  logic [6:0]  vl = '0;
  logic        abort = 1'b0;
  logic        ram_rd;
  logic [5:0]  ram_addr;
  logic [63:0] ram_dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef VREG_SEQ_STRIDE_EN
  logic [5:0]  stride = 6'd1;
`endif
  logic [63:0] mem [64];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0] b;
    logic [6:0] l;
    int         mode;
    int         exp_done;
    logic       ab;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_dout <= mem[ram_addr];

  vreg_read_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .vl        (vl),
`ifdef VREG_SEQ_STRIDE_EN
    .stride    (stride),
`endif
    .abort     (abort),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [5:0] b, input logic [6:0] l, input int mode,
                         input int exp_done, input logic ab, input logic [5:0] s);
    int nrd, nout, first_rd, first_ov, max_occ, cyc;
    logic held, hl, fin;
    logic [63:0] hd;
    logic [5:0] inc, ea;
`ifdef VREG_SEQ_STRIDE_EN
    inc = s;
`else
    inc = 6'd1 | (s & 6'd0);
`endif
    @(negedge clk);
    start = 1'b1; base = b; vl = l; abort = ab;
`ifdef VREG_SEQ_STRIDE_EN
    stride = s;
`endif
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    nrd = 0; nout = 0; first_rd = -1; first_ov = -1; max_occ = 0;
    held = 1'b0; hl = 1'b0; hd = '0; fin = 1'b0;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      out_ready = mode == 0 ? 1'b1 : (cyc % 2 == 0);
      if (cyc == 1 && l != 0) begin
        start = 1'b1; base = b ^ 6'h2a; vl = 7'd5;
      end else start = 1'b0;
      #1;
      if (nrd - nout > max_occ) max_occ = nrd - nout;
      if (held) begin
        chk("hold_data", out_data, hd);
        chk("hold_last", {63'd0, out_last}, {63'd0, hl});
      end
      held = out_valid && !out_ready; hd = out_data; hl = out_last;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (ram_rd) begin
        if (first_rd < 0) first_rd = cyc;
        ea = b + 6'(nrd) * inc;
        chk("ram_addr", {58'd0, ram_addr}, {58'd0, ea});
        nrd++;
      end
      if (out_valid && out_ready) begin
        ea = b + 6'(nout) * inc;
        chk("out_data", out_data, mem[ea]);
        chk("out_last", {63'd0, out_last}, {63'd0, nout == int'(l) - 1});
        nout++;
      end
      if (done) begin
        fin = 1'b1;
        if (exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
      end
    end
    start = 1'b0;
    chk("timeout", {63'd0, fin}, 64'd1);
    chk("n_issued", 64'(nrd), 64'(l));
    chk("n_out", 64'(nout), 64'(l));
    if (l != 0) begin
      chk("first_rd_cycle", 64'(first_rd), 64'd0);
      chk("first_valid_cycle", 64'(first_ov), 64'd2);
    end
    chk("max_buffered", 64'(max_occ <= 2), 64'd1);
    @(negedge clk); #1;
    chk("done_pulse_width", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int popped;
    for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 16'(i), 32'(i) * 32'h01010101 + 32'h5A};
    tv[0] = '{b: 6'd0,  l: 7'd4,  mode: 0, exp_done: 6,  ab: 1'b0};
    tv[1] = '{b: 6'd62, l: 7'd4,  mode: 0, exp_done: 6,  ab: 1'b0};
    tv[2] = '{b: 6'd0,  l: 7'd64, mode: 1, exp_done: -1, ab: 1'b0};
    tv[3] = '{b: 6'd5,  l: 7'd0,  mode: 0, exp_done: 0,  ab: 1'b0};
    tv[4] = '{b: 6'd10, l: 7'd1,  mode: 0, exp_done: 3,  ab: 1'b0};
    tv[5] = '{b: 6'd0,  l: 7'd64, mode: 0, exp_done: 66, ab: 1'b0};
    tv[6] = '{b: 6'd63, l: 7'd2,  mode: 0, exp_done: 4,  ab: 1'b0};
    tv[7] = '{b: 6'd40, l: 7'd2,  mode: 0, exp_done: 4,  ab: 1'b1};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ram_rd", {63'd0, ram_rd}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_cmd(tv[i].b, tv[i].l, tv[i].mode, tv[i].exp_done, tv[i].ab, 6'd1);
    // abort ignored while idle
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);
    chk("idle_abort_done", {63'd0, done}, 64'd0);
    // abort after the third element with the consumer stalled
    @(negedge clk); start = 1'b1; base = 6'd20; vl = 7'd8;
    @(negedge clk); start = 1'b0; out_ready = 1'b1;
    popped = 0;
    for (int c = 0; c < 50 && popped < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        chk("abort_pre_data", out_data, mem[6'd20 + 6'(popped)]);
        popped++;
      end
    end
    chk("abort_pre_count", 64'(popped), 64'd3);
    @(negedge clk); out_ready = 1'b0; abort = 1'b1; #1;
    chk("abort_no_issue", {63'd0, ram_rd}, 64'd0);
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd1);
    @(negedge clk); #1;
    chk("abort_done_width", {63'd0, done}, 64'd0);
    run_cmd(6'd3, 7'd3, 0, 5, 1'b0, 6'd1);
    // reset in the middle of a command
    @(negedge clk); start = 1'b1; base = 6'd0; vl = 7'd16;
    @(negedge clk); start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_ram", {57'd0, ram_rd, ram_addr}, 64'd0);
    chk("mid_rst_out", {62'd0, out_valid, out_last}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_status", {62'd0, busy, done}, 64'd0);
    run_cmd(6'd8, 7'd3, 0, 5, 1'b0, 6'd1);
`ifdef VREG_SEQ_STRIDE_EN
    run_cmd(6'd1, 7'd3, 0, 5, 1'b0, 6'd3);
    run_cmd(6'd9, 7'd3, 0, 5, 1'b0, 6'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
